// File: rtl/wb_word_adapter.sv
// 32-bit Wishbone classic slave to 8-bit Wishbone classic master: each word access becomes byte accesses on lanes 0..3.
// Optional feature: define WB_WORD_ADAPTER_SEL_EN to skip byte lanes whose sel bit is clear.
module wb_word_adapter #(
  parameter int ADR_WIDTH = 24
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_stb_i,
  input  logic                 wbs_we_i,
  input  logic [ADR_WIDTH-1:0] wbs_adr_i,
  input  logic [31:0]          wbs_dat_i,
  input  logic [3:0]           wbs_sel_i,
  output logic                 wbs_ack_o,
  output logic                 wbs_err_o,
  output logic [31:0]          wbs_dat_o,
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  output logic                 wbm_we_o,
  output logic [ADR_WIDTH-1:0] wbm_adr_o,
  output logic [7:0]           wbm_dat_o,
  input  logic                 wbm_ack_i,
  input  logic                 wbm_err_i,
  input  logic [7:0]           wbm_dat_i
);

  typedef enum logic [1:0] {IDLE, REQ, GAP, DONE} state_t;

  state_t               state;
  logic [ADR_WIDTH-1:0] adr_q;
  logic [ADR_WIDTH-1:0] adr_word;
  logic                 we_q;
  logic [31:0]          dat_q;
  logic [31:0]          rd_buf;
  logic [31:0]          rd_merged;
  logic [3:0]           mask_q;
  logic [3:0]           lane_mask;
  logic [1:0]           k;
  logic [2:0]           first_sel;
  logic [2:0]           next_sel;

  // Lowest enabled lane at or above 'from'; 3'd4 means none is left.
  function automatic logic [2:0] first_lane(input logic [3:0] m, input logic [2:0] from);
    logic [2:0] r;
    r = 3'd4;
    for (int i = 3; i >= 0; i--)
      if (m[i] && (3'(i) >= from)) r = 3'(i);
    return r;
  endfunction

  always_comb begin
`ifdef WB_WORD_ADAPTER_SEL_EN
    lane_mask = wbs_sel_i;
`else
    lane_mask = wbs_sel_i | 4'hF;
`endif
    adr_word  = wbs_adr_i & ~ADR_WIDTH'(3);
    first_sel = first_lane(lane_mask, 3'd0);
    next_sel  = first_lane(mask_q, {1'b0, k} + 3'd1);
    rd_merged = rd_buf;
    rd_merged[{k, 3'b000} +: 8] = wbm_dat_i;
  end

  assign wbm_cyc_o = wbm_stb_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      adr_q     <= '0;
      we_q      <= 1'b0;
      dat_q     <= '0;
      mask_q    <= '0;
      rd_buf    <= '0;
      k         <= 2'd0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      wbs_ack_o <= 1'b0;
      wbs_err_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= 1'b0;
      wbs_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (wbs_cyc_i && wbs_stb_i && !wbs_ack_o && !wbs_err_o) begin
            adr_q  <= adr_word;
            we_q   <= wbs_we_i;
            dat_q  <= wbs_dat_i;
            mask_q <= lane_mask;
            rd_buf <= '0;
            k      <= 2'd0;
            if (first_sel[2]) begin
              state <= DONE;
            end else begin
              k         <= first_sel[1:0];
              state     <= REQ;
              wbm_stb_o <= 1'b1;
              wbm_we_o  <= wbs_we_i;
              wbm_adr_o <= adr_word | ADR_WIDTH'(first_sel[1:0]);
              wbm_dat_o <= wbs_dat_i[{first_sel[1:0], 3'b000} +: 8];
            end
          end
        end
        REQ: begin
          // Upstream abort wins over any downstream response in the same cycle.
          if (!wbs_cyc_i) begin
            wbm_stb_o <= 1'b0;
            state     <= IDLE;
          end else if (wbm_err_i) begin
            wbm_stb_o <= 1'b0;
            wbs_err_o <= 1'b1;
            state     <= IDLE;
          end else if (wbm_ack_i) begin
            wbm_stb_o <= 1'b0;
            if (!we_q) rd_buf <= rd_merged;
            if (next_sel[2]) begin
              state     <= DONE;
              wbs_ack_o <= 1'b1;
              if (!we_q) wbs_dat_o <= rd_merged;
            end else begin
              k     <= next_sel[1:0];
              state <= GAP;
            end
          end
        end
        GAP: begin
          if (!wbs_cyc_i) begin
            state <= IDLE;
          end else begin
            state     <= REQ;
            wbm_stb_o <= 1'b1;
            wbm_adr_o <= adr_q | ADR_WIDTH'(k);
            wbm_dat_o <= dat_q[{k, 3'b000} +: 8];
          end
        end
        DONE: begin
          // Entered with ack already set after a transfer; with no lanes selected, spend one cycle before acking.
          if (!wbs_cyc_i || wbs_ack_o) begin
            state <= IDLE;
          end else begin
            wbs_ack_o <= 1'b1;
            if (!we_q) wbs_dat_o <= rd_buf;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_word_adapter.sv
// Bench for wb_word_adapter: directed table, reset-in-flight sequence and randomized transfers against a word-level model.
module tb_wb_word_adapter;
  localparam int AW = 24;
`ifdef WB_WORD_ADAPTER_SEL_EN
  localparam bit SEL = 1'b1;
`else
  localparam bit SEL = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
  logic [AW-1:0] wbs_adr_i = '0;
  logic [31:0]   wbs_dat_i = '0;
  logic [3:0]    wbs_sel_i = '0;
  logic          wbs_ack_o, wbs_err_o;
  logic [31:0]   wbs_dat_o;
  logic          wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [AW-1:0] wbm_adr_o;
  logic [7:0]    wbm_dat_o;
  logic          wbm_ack_i = 1'b0, wbm_err_i = 1'b0;
  logic [7:0]    wbm_dat_i = '0;

  wb_word_adapter #(.ADR_WIDTH(AW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
    .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o), .wbs_dat_o(wbs_dat_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_dat_i(wbm_dat_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [AW-1:0] adr;
    logic          we;
    logic [31:0]   dat;
    logic [3:0]    sel;
    int            lat;
    int            err_at;
    int            drop_at;
    logic          e_ack;
    logic          e_err;
    logic [31:0]   e_word;
    int            e_cyc;
  } vec_t;

  typedef struct {
    logic [AW-1:0] adr;
    logic          we;
    logic [7:0]    dat;
    int            gap;
  } acc_t;

  acc_t        log_q[$];
  acc_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          lat_m = 3;
  int          err_at_m = -1;
  int          stab_viol = 0;
  int          cyc_viol = 0;
  logic [31:0] model_word = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Mock 8-bit slave: responds lat_m cycles into a strobe, byte = adr[7:0]^A5, optional error on one pulse index.
  int            cnt = 0;
  logic          prev_stb = 1'b0;
  int            low_cnt = 0;
  logic [32:0]   prev_bus = '0;
  always @(posedge clk_i) begin
    if (wbm_stb_o && !prev_stb) log_q.push_back('{wbm_adr_o, wbm_we_o, wbm_dat_o, low_cnt});
    if (wbm_stb_o && prev_stb && ({wbm_adr_o, wbm_we_o, wbm_dat_o} != prev_bus)) stab_viol++;
    low_cnt  <= wbm_stb_o ? 0 : low_cnt + 1;
    prev_stb <= wbm_stb_o;
    prev_bus <= {wbm_adr_o, wbm_we_o, wbm_dat_o};
    if (!wbm_stb_o || wbm_ack_i || wbm_err_i) begin
      cnt       <= 0;
      wbm_ack_i <= 1'b0;
      wbm_err_i <= 1'b0;
    end else begin
      cnt <= cnt + 1;
      if (cnt == lat_m - 1) begin
        if (int'(log_q.size()) - 1 == err_at_m) wbm_err_i <= 1'b1;
        else begin
          wbm_ack_i <= 1'b1;
          wbm_dat_i <= wbm_adr_o[7:0] ^ 8'hA5;
        end
      end
    end
  end

  always @(negedge clk_i) if (wbm_cyc_o !== wbm_stb_o) cyc_viol++;

  // Word-level reference: which byte accesses happen, the outcome, and cycles from accept to ack/err.
  task automatic model(input vec_t v, output logic a, output logic e, output logic [31:0] w,
                       output int cyc, output int n_iss);
    logic [3:0]    m;
    logic [31:0]   word;
    logic [AW-1:0] ba;
    int            n;
    m    = SEL ? v.sel : 4'hF;
    word = '0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        ba = (v.adr & ~24'h3) + 24'(i);
        exp_q.push_back('{ba, v.we, 8'(v.dat >> (8 * i)), 1});
        word[8*i +: 8] = ba[7:0] ^ 8'hA5;
      end
    end
    n = exp_q.size();
    if (v.err_at >= 0 && v.err_at < n) begin
      a = 1'b0; e = 1'b1; w = model_word; cyc = (v.err_at + 1) * (v.lat + 2); n_iss = v.err_at + 1;
    end else if (v.drop_at >= 0 && v.drop_at < n) begin
      a = 1'b0; e = 1'b0; w = model_word; cyc = 0; n_iss = v.drop_at + 1;
    end else begin
      a = 1'b1; e = 1'b0; w = v.we ? model_word : word;
      cyc = (n == 0) ? 2 : n * (v.lat + 2); n_iss = n;
    end
  endtask

  task automatic run(input vec_t v, output logic got_ack, output logic got_err, output int cyc_n);
    lat_m = v.lat; err_at_m = v.err_at; log_q.delete();
    got_ack = 1'b0; got_err = 1'b0; cyc_n = 0;
    @(posedge clk_i); #1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = v.we;
    wbs_adr_i = v.adr; wbs_dat_i = v.dat; wbs_sel_i = v.sel;
    @(posedge clk_i);
    for (int c = 0; c < 200 && !got_ack && !got_err; c++) begin
      @(negedge clk_i);
      cyc_n++;
      got_ack = wbs_ack_o;
      got_err = wbs_err_o;
      if (!got_ack && !got_err && v.drop_at >= 0 && int'(log_q.size()) == v.drop_at + 1) begin
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(negedge clk_i);
        chk("drop_stb_low", 64'(wbm_stb_o), 64'd0);
        repeat (6) begin
          if (wbs_ack_o) got_ack = 1'b1;
          if (wbs_err_o) got_err = 1'b1;
          @(negedge clk_i);
        end
        break;
      end
    end
    if (got_ack || got_err) begin
      @(posedge clk_i); #1;
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      @(negedge clk_i);
      chk("single_pulse", 64'({wbs_ack_o, wbs_err_o}), 64'd0);
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
  endtask

  task automatic check_txn(input string tag, input vec_t v, input logic e_ack, input logic e_err,
                           input logic [31:0] e_word, input int e_cyc, input int n_iss);
    logic got_ack, got_err;
    int   cyc_n;
    run(v, got_ack, got_err, cyc_n);
    chk({tag, "_ack"}, 64'(got_ack), 64'(e_ack));
    chk({tag, "_err"}, 64'(got_err), 64'(e_err));
    if (e_ack || e_err) chk({tag, "_latency"}, 64'(cyc_n), 64'(e_cyc));
    chk({tag, "_rdata"}, 64'(wbs_dat_o), 64'(e_word));
    chk({tag, "_nacc"}, 64'(log_q.size()), 64'(n_iss));
    for (int i = 0; i < n_iss && i < int'(log_q.size()); i++) begin
      chk({tag, "_acc"}, 64'({log_q[i].adr, log_q[i].we, log_q[i].dat}),
          64'({exp_q[i].adr, exp_q[i].we, exp_q[i].dat}));
      if (i > 0) chk({tag, "_gap"}, 64'(log_q[i].gap), 64'd1);
    end
  endtask

  vec_t tbl[10];

  initial begin
    logic        ea, ee;
    logic [31:0] ew;
    int          ec, ni, mode;
    vec_t        v;
    bit          hit;

    tbl[0] = '{24'h000104, 1'b0, 32'h0, 4'hF, 3, -1, -1, 1'b1, 1'b0, 32'hA2A3A0A1, 20};
    tbl[1] = '{24'h00020B, 1'b1, 32'hDEADBEEF, 4'hF, 3, -1, -1, 1'b1, 1'b0, 32'hA2A3A0A1, 20};
    tbl[2] = '{24'h000000, 1'b0, 32'h0, 4'hF, 3, -1, -1, 1'b1, 1'b0, 32'hA6A7A4A5, 20};
    tbl[3] = '{24'h000104, 1'b0, 32'h0, 4'hF, 3, 1, -1, 1'b0, 1'b1, 32'hA6A7A4A5, 10};
    tbl[4] = '{24'h000104, 1'b0, 32'h0, 4'hF, 3, -1, 2, 1'b0, 1'b0, 32'hA6A7A4A5, 0};
    tbl[5] = '{24'h000104, 1'b0, 32'h0, 4'hF, 3, -1, -1, 1'b1, 1'b0, 32'hA2A3A0A1, 20};
    tbl[6] = '{24'h000104, 1'b0, 32'h0, 4'hA, 3, -1, -1, 1'b1, 1'b0,
               SEL ? 32'hA200A000 : 32'hA2A3A0A1, SEL ? 10 : 20};
    tbl[7] = '{24'h000104, 1'b0, 32'h0, 4'h0, 3, -1, -1, 1'b1, 1'b0,
               SEL ? 32'h00000000 : 32'hA2A3A0A1, SEL ? 2 : 20};
    tbl[8] = '{24'h000010, 1'b1, 32'h12345678, 4'h5, 1, -1, -1, 1'b1, 1'b0,
               SEL ? 32'h00000000 : 32'hA2A3A0A1, SEL ? 6 : 12};
    tbl[9] = '{24'h0000FC, 1'b0, 32'h0, 4'hF, 2, 3, -1, 1'b0, 1'b1,
               SEL ? 32'h00000000 : 32'hA2A3A0A1, 16};

    repeat (3) @(negedge clk_i);
    chk("reset_bus", 64'({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o}), 64'd0);
    chk("reset_slave", 64'({wbs_ack_o, wbs_err_o, wbs_dat_o}), 64'd0);
    rst_ni = 1'b1;

    for (int i = 0; i < 10; i++) begin
      model(tbl[i], ea, ee, ew, ec, ni);
      check_txn($sformatf("vec%0d", i), tbl[i], tbl[i].e_ack, tbl[i].e_err, tbl[i].e_word, tbl[i].e_cyc, ni);
      model_word = tbl[i].e_word;
    end

    // Reset while lane 1 of a read is on the bus.
    lat_m = 3; err_at_m = -1; log_q.delete();
    @(posedge clk_i); #1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 24'h000104; wbs_sel_i = 4'hF;
    hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk_i);
      hit = (log_q.size() == 2) && wbm_stb_o;
    end
    chk("rst_reached_lane1", 64'(hit), 64'd1);
    #1 rst_ni = 1'b0;
    #1;
    chk("rst_async_bus", 64'({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o}), 64'd0);
    chk("rst_async_slave", 64'({wbs_ack_o, wbs_err_o, wbs_dat_o}), 64'd0);
    repeat (2) @(negedge clk_i);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    rst_ni = 1'b1;
    hit = 1'b0;
    repeat (8) begin
      @(negedge clk_i);
      if (wbs_ack_o || wbs_err_o || wbm_stb_o) hit = 1'b1;
    end
    chk("rst_release_quiet", 64'(hit), 64'd0);
    model_word = '0;
    chk("rst_rdata_cleared", 64'(wbs_dat_o), 64'd0);

    for (int i = 0; i < 40; i++) begin
      v.adr = 24'($urandom);
      v.we = 1'($urandom_range(0, 1));
      v.dat = $urandom;
      v.sel = 4'($urandom);
      v.lat = $urandom_range(1, 4);
      v.err_at = -1;
      v.drop_at = -1;
      mode = $urandom_range(0, 5);
      if (mode == 0) v.err_at = $urandom_range(0, 3);
      else if (mode == 1) v.drop_at = $urandom_range(0, 3);
      model(v, ea, ee, ew, ec, ni);
      check_txn($sformatf("rnd%0d", i), v, ea, ee, ew, ec, ni);
      model_word = ew;
    end

    chk("stb_stable", 64'(stab_viol), 64'd0);
    chk("cyc_eq_stb", 64'(cyc_viol), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
